// File: rtl/c1541_pkg.sv
// Shared D64 geometry constants, track/LBA helpers and the loader state encoding
// for the 1541 track loader.
package c1541_pkg;

    localparam int NUM_TRACKS  = 35;
    localparam int ZONE1_LAST  = 17;
    localparam int ZONE2_LAST  = 24;
    localparam int ZONE3_LAST  = 30;
    localparam int ZONE1_SECTS = 21;
    localparam int ZONE2_SECTS = 19;
    localparam int ZONE3_SECTS = 18;
    localparam int ZONE4_SECTS = 17;
    localparam int ZONE1_BASE  = 0;
    localparam int ZONE2_BASE  = 357;
    localparam int ZONE3_BASE  = 490;
    localparam int ZONE4_BASE  = 598;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_SCAN,
        ST_WB_REQ,
        ST_WB_XFER,
        ST_RD_REQ,
        ST_RD_XFER,
        ST_DONE
    } loader_state_t;

    function automatic logic [5:0] clamp_track(input logic [5:0] t);
        if (t == 6'd0) return 6'd1;
        if (t > 6'(NUM_TRACKS)) return 6'(NUM_TRACKS);
        return t;
    endfunction

    function automatic logic [4:0] sectors_per_track(input logic [5:0] t);
        if (t <= 6'(ZONE1_LAST)) return 5'(ZONE1_SECTS);
        if (t <= 6'(ZONE2_LAST)) return 5'(ZONE2_SECTS);
        if (t <= 6'(ZONE3_LAST)) return 5'(ZONE3_SECTS);
        return 5'(ZONE4_SECTS);
    endfunction

    // Only meaningful for tracks 1..35; callers never pass track 0.
    function automatic logic [9:0] start_lba(input logic [5:0] t);
        int ti;
        ti = int'(t);
        if (ti <= ZONE1_LAST) return 10'(ZONE1_BASE + (ti - 1) * ZONE1_SECTS);
        if (ti <= ZONE2_LAST) return 10'(ZONE2_BASE + (ti - ZONE1_LAST - 1) * ZONE2_SECTS);
        if (ti <= ZONE3_LAST) return 10'(ZONE3_BASE + (ti - ZONE2_LAST - 1) * ZONE3_SECTS);
        return 10'(ZONE4_BASE + (ti - ZONE3_LAST - 1) * ZONE4_SECTS);
    endfunction

    function automatic logic [31:0] lba_of(input logic [5:0] t, input logic [4:0] s);
        return 32'(start_lba(t)) + 32'(s);
    endfunction

endpackage

// File: rtl/c1541_track_buf.sv
// One-track sector buffer: true dual-port synchronous RAM with registered reads on
// both ports. Addresses beyond DEPTH are ignored on write and read back as zero.
module c1541_track_buf #(
    parameter int DEPTH = 5376,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_di,
    input  logic          a_we,
    output logic [7:0]    a_do,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_di,
    input  logic          b_we,
    output logic [7:0]    b_do
);
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [7:0] mem [DEPTH];
    logic       a_ok;
    logic       b_ok;

    assign a_ok = {1'b0, a_addr} < DEPTH_V;
    assign b_ok = {1'b0, b_addr} < DEPTH_V;

    // On a same-address collision the SD-side write lands last.
    always_ff @(posedge clk) begin
        if (a_we && a_ok) mem[a_addr] <= a_di;
        if (b_we && b_ok) mem[b_addr] <= b_di;
        a_do <= a_ok ? mem[a_addr] : 8'h00;
        b_do <= b_ok ? mem[b_addr] : 8'h00;
    end

endmodule

// File: rtl/c1541_track_loader.sv
// Keeps the GCR-side track buffer filled with the current D64 track, writing dirty
// sectors back to the image before any reload.
module c1541_track_loader
    import c1541_pkg::*;
#(
    parameter int SETTLE_CYCLES = 32000,
    parameter int SECT_MAX      = 21
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic [5:0]  track,
    input  logic [4:0]  sector,
    input  logic [7:0]  byte_addr,
    input  logic [7:0]  ram_di,
    input  logic        ram_we,
    output logic [7:0]  ram_do,
    output logic        ram_ready,
    input  logic        img_mounted,
    input  logic        img_readonly,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr,
    output logic        busy
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    // SD handshake: sd_rd/sd_wr stay high with sd_lba stable until sd_ack rises;
    // the block is finished, and the next request may start, when sd_ack falls.
    loader_state_t       state, state_n;
    logic [5:0]          trk_c, prev_trk, loaded_track, target;
    logic [CW-1:0]       settle_cnt;
    logic                settled, load_req;
    logic                mount_pend, mnt, mount_apply;
    logic                ack_q, ack_rise, ack_fall;
    logic [4:0]          cur_sec, low_sec;
    logic [SECT_MAX-1:0] dirty;
    logic                wb_pending, last_sec, leave_idle, ready_q;
    logic                gcr_we, sd_we;

    assign trk_c    = clamp_track(track);
    assign settled  = settle_cnt == CW'(SETTLE_CYCLES);
    assign load_req = settled && (trk_c != loaded_track);
    assign mnt      = mount_pend | img_mounted;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign last_sec = cur_sec == (sectors_per_track(target) - 5'd1);
    assign wb_pending = (|dirty) && (loaded_track != 6'd0) && !img_readonly;
    assign leave_idle = (state == ST_IDLE) && (load_req || mnt);
    assign gcr_we   = ram_we & ram_ready;
    assign sd_we    = sd_buff_wr && (state == ST_RD_XFER);

    // A pending mount waits for a quiet point so no SD handshake is cut short.
    assign mount_apply = mnt && ((state == ST_IDLE) || (state == ST_DONE) ||
                         (ack_fall && ((state == ST_WB_XFER) || (state == ST_RD_XFER))));

    always_comb begin
        low_sec = 5'd0;
        for (int i = SECT_MAX - 1; i >= 0; i--) begin
            if (dirty[i]) low_sec = 5'(i);
        end
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            prev_trk   <= 6'd0;
            settle_cnt <= '0;
        end else if (trk_c != prev_trk) begin
            prev_trk   <= trk_c;
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk32) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (leave_idle) state_n = ST_WB_SCAN;
            ST_WB_SCAN: state_n = wb_pending ? ST_WB_REQ : ST_RD_REQ;
            ST_WB_REQ:  if (ack_rise) state_n = ST_WB_XFER;
            ST_WB_XFER: if (ack_fall) state_n = ST_WB_SCAN;
            ST_RD_REQ:  if (ack_rise) state_n = ST_RD_XFER;
            ST_RD_XFER: begin
                if (ack_fall) begin
                    if (mnt)                              state_n = ST_WB_SCAN;
                    else if (last_sec || trk_c != target) state_n = ST_DONE;
                    else                                  state_n = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                if (mnt)                        state_n = ST_WB_SCAN;
                else if (trk_c == loaded_track) state_n = ST_IDLE;
                else                            state_n = ST_RD_REQ;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        sd_rd     = state == ST_RD_REQ;
        sd_wr     = state == ST_WB_REQ;
        busy      = state != ST_IDLE;
        ram_ready = ready_q && (state == ST_IDLE) && !leave_idle;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            ack_q        <= 1'b0;
            mount_pend   <= 1'b0;
            dirty        <= '0;
            loaded_track <= 6'd0;
            target       <= 6'd0;
            cur_sec      <= 5'd0;
            sd_lba       <= 32'd0;
            ready_q      <= 1'b0;
        end else begin
            ack_q <= sd_ack;
            if (img_mounted) mount_pend <= 1'b1;
            if (gcr_we && !img_readonly && int'(sector) < SECT_MAX) dirty[sector] <= 1'b1;
            case (state)
                ST_IDLE: if (leave_idle) ready_q <= 1'b0;
                ST_WB_SCAN: begin
                    if (wb_pending) begin
                        cur_sec <= low_sec;
                        sd_lba  <= lba_of(loaded_track, low_sec);
                    end else begin
                        // The buffer is about to be overwritten, so the old track is no longer valid.
                        cur_sec      <= 5'd0;
                        target       <= trk_c;
                        loaded_track <= 6'd0;
                        sd_lba       <= lba_of(trk_c, 5'd0);
                    end
                end
                ST_WB_XFER: if (ack_fall) dirty[cur_sec] <= 1'b0;
                ST_RD_XFER: begin
                    if (ack_fall) begin
                        if (last_sec) begin
                            loaded_track <= target;
                        end else if (trk_c == target) begin
                            cur_sec <= cur_sec + 5'd1;
                            sd_lba  <= lba_of(target, cur_sec + 5'd1);
                        end
                    end
                end
                ST_DONE: begin
                    if (trk_c == loaded_track) begin
                        ready_q <= 1'b1;
                    end else begin
                        target       <= trk_c;
                        cur_sec      <= 5'd0;
                        loaded_track <= 6'd0;
                        sd_lba       <= lba_of(trk_c, 5'd0);
                    end
                end
                default: ;
            endcase
            if (mount_apply) begin
                dirty        <= '0;
                loaded_track <= 6'd0;
                mount_pend   <= 1'b0;
                ready_q      <= 1'b0;
            end
        end
    end

    c1541_track_buf #(
        .DEPTH (SECT_MAX * 256),
        .AW    (13)
    ) u_buf (
        .clk    (clk32),
        .a_addr ({sector, byte_addr}),
        .a_di   (ram_di),
        .a_we   (gcr_we),
        .a_do   (ram_do),
        .b_addr ({cur_sec, sd_buff_addr}),
        .b_di   (sd_buff_dout),
        .b_we   (sd_we),
        .b_do   (sd_buff_din)
    );

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench for the track loader: an SD host model serves blocks from a
// synthetic image and checks each request against a queue of expected operations.
module tb_c1541_track_loader;
    localparam int SETTLE = 64;

    logic        clk32 = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic [4:0]  sector;
    logic [7:0]  byte_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  ram_do;
    logic        ram_ready;
    logic        img_mounted;
    logic        img_readonly;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Expected SD operations: {is_write, lba}; write-back data bytes 0 and 1.
    logic [32:0] exp_q[$];
    logic [7:0]  exp_wb_q[$];

    always #5 clk32 = ~clk32;

    c1541_track_loader #(
        .SETTLE_CYCLES (SETTLE),
        .SECT_MAX      (21)
    ) dut (
        .clk32        (clk32),
        .reset        (reset),
        .track        (track),
        .sector       (sector),
        .byte_addr    (byte_addr),
        .ram_di       (ram_di),
        .ram_we       (ram_we),
        .ram_do       (ram_do),
        .ram_ready    (ram_ready),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .busy         (busy)
    );

    function automatic logic [7:0] img_byte(input int lba, input int off);
        int v;
        v = lba * 37 + off * 11 + 3;
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_reads(input int first, input int last);
        for (int l = first; l <= last; l++) exp_q.push_back({1'b0, 32'(l)});
    endtask

    task automatic gcr_write(input logic [4:0] s, input logic [7:0] b, input logic [7:0] d);
        sector = s; byte_addr = b; ram_di = d; ram_we = 1'b1;
        @(negedge clk32);
        ram_we = 1'b0;
    endtask

    task automatic gcr_check(input string tag, input logic [4:0] s, input logic [7:0] b,
                             input logic [7:0] exp);
        sector = s; byte_addr = b;
        @(negedge clk32);
        @(negedge clk32);
        check(tag, 33'(ram_do), 33'(exp));
    endtask

    // Waits for the buffer to go invalid, then valid again with every expected op served.
    task automatic load_wait(input bit poke_write);
        int n;
        n = 0;
        while (ram_ready && n < 1000) begin @(negedge clk32); n++; end
        check("ready_dropped", 33'(ram_ready), 33'd0);
        if (poke_write) gcr_write(5'd2, 8'h00, 8'h77);
        n = 0;
        while (!ram_ready && n < 12000) begin @(negedge clk32); n++; end
        check("ready_rose", 33'(ram_ready), 33'd1);
        check("ops_drained", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin : sd_host
        logic [32:0] op;
        logic [32:0] exp;
        logic [7:0]  wb_buf [256];
        sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 8'd0; sd_buff_wr = 1'b0;
        forever begin
            @(negedge clk32);
            if (!reset && (sd_rd || sd_wr)) begin
                op = {sd_wr, sd_lba};
                check("op_expected", 33'(exp_q.size() != 0), 33'd1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("sd_op", op, exp);
                end
                sd_ack = 1'b1;
                @(negedge clk32);
                if (op[32]) begin
                    for (int i = 0; i < 256; i++) begin
                        sd_buff_addr = 8'(i);
                        @(negedge clk32);
                        wb_buf[i] = sd_buff_din;
                    end
                    if (exp_wb_q.size() >= 2) begin
                        check("wb_byte0", 33'(wb_buf[0]), 33'(exp_wb_q.pop_front()));
                        check("wb_byte1", 33'(wb_buf[1]), 33'(exp_wb_q.pop_front()));
                    end
                end else begin
                    for (int i = 0; i < 256; i++) begin
                        sd_buff_addr = 8'(i);
                        sd_buff_dout = img_byte(int'(op[31:0]), i);
                        sd_buff_wr   = 1'b1;
                        @(negedge clk32);
                    end
                    sd_buff_wr = 1'b0;
                end
                sd_ack = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int n;
        reset = 1'b1; track = 6'd1; sector = 5'd0; byte_addr = 8'd0; ram_di = 8'd0;
        ram_we = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        repeat (4) @(negedge clk32);
        check("rst_ram_ready", 33'(ram_ready), 33'd0);
        check("rst_sd_rd", 33'(sd_rd), 33'd0);
        check("rst_sd_wr", 33'(sd_wr), 33'd0);
        check("rst_sd_lba", 33'(sd_lba), 33'd0);
        check("rst_busy", 33'(busy), 33'd0);

        // Track 1 from reset.
        push_reads(0, 20);
        reset = 1'b0;
        load_wait(1'b0);
        gcr_check("t1_ram_do_3_10", 5'd3, 8'h10, img_byte(3, 16));
        gcr_check("t1_ram_do_20_ff", 5'd20, 8'hFF, img_byte(20, 255));

        // Dirty sector 5 is written back before track 2 loads.
        gcr_write(5'd5, 8'h00, 8'hAA);
        exp_q.push_back({1'b1, 32'd5});
        exp_wb_q.push_back(8'hAA);
        exp_wb_q.push_back(img_byte(5, 1));
        push_reads(21, 41);
        track = 6'd2;
        load_wait(1'b0);

        // Zone 2 start, no write-back.
        push_reads(357, 375);
        track = 6'd18;
        load_wait(1'b0);

        // Track changes during the LBA 7 transfer.
        push_reads(0, 7);
        push_reads(21, 41);
        track = 6'd1;
        n = 0;
        while (!(sd_ack && sd_lba == 32'd7) && n < 8000) begin @(negedge clk32); n++; end
        check("saw_lba7", 33'(sd_ack && sd_lba == 32'd7), 33'd1);
        track = 6'd2;
        load_wait(1'b0);

        // Read-only image: writes never mark sectors dirty.
        img_readonly = 1'b1;
        gcr_write(5'd0, 8'h00, 8'h55);
        push_reads(42, 62);
        track = 6'd3;
        load_wait(1'b0);
        img_readonly = 1'b0;

        // Track 0 clamps to 1; a GCR write while not ready is dropped.
        push_reads(0, 20);
        track = 6'd0;
        load_wait(1'b1);

        // Track 40 clamps to 35.
        push_reads(666, 682);
        track = 6'd40;
        load_wait(1'b0);
        gcr_check("t35_ram_do_16_ff", 5'd16, 8'hFF, img_byte(682, 255));

        // Mount discards the dirty sector and reloads the current track.
        gcr_write(5'd0, 8'h00, 8'hAA);
        push_reads(666, 682);
        img_mounted = 1'b1;
        #1;
        check("mount_ready_drop", 33'(ram_ready), 33'd0);
        @(negedge clk32);
        img_mounted = 1'b0;
        load_wait(1'b0);
        gcr_check("mount_ram_do_0_0", 5'd0, 8'h00, img_byte(666, 0));

        repeat (10) @(negedge clk32);
        check("final_idle", 33'(busy), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c1541_track_loader.md
Name: c1541_track_loader

Overview:
- Owns the one-track buffer RAM that the GCR stage reads from and writes into.
- Fetches all sectors of the current track from the mounted D64 image over the block-level SD interface.
- Writes modified sectors back to the image before moving to another track.
- Drives ram_ready to the GCR stage; ram_ready is low whenever the buffer contents are not valid for the current track.

Parameters:
- SETTLE_CYCLES, 32000: track value must be stable this many clk32 cycles before a load starts (1 ms at 32 MHz).
- SECT_MAX, 21: buffer depth in sectors; buffer is SECT_MAX*256 bytes.

Ports:
- clk32  in  1  system clock, 32 MHz
- reset  in  1  synchronous, active-high
- track  in  6  requested D64 track (1..35)
- sector  in  5  GCR-side sector index
- byte_addr  in  8  GCR-side byte index
- ram_di  in  8  GCR-side write data
- ram_we  in  1  GCR-side write strobe
- ram_do  out  8  GCR-side read data, one-cycle registered
- ram_ready  out  1  buffer valid for current track
- img_mounted  in  1  one-cycle pulse, new image inserted
- img_readonly  in  1  image write-protected
- sd_lba  out  32  256-byte block address
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  transfer in progress
- sd_buff_addr  in  8  byte index within block
- sd_buff_dout  in  8  data from SD
- sd_buff_din  out  8  data to SD, one-cycle registered
- sd_buff_wr  in  1  SD byte write strobe
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE, ram_ready=0, sd_rd=sd_wr=0, sd_lba=0, dirty=0, loaded_track=0 (invalid), settle counter=0. The first stable track then triggers a load.
- Track clamp: 0 -> 1, >35 -> 35.
- Sector counts: tracks 1-17 have 21 sectors; 18-24 have 19; 25-30 have 18; 31-35 have 17.
- Start LBA:
  - t<=17: (t-1)*21
  - t<=24: 357+(t-18)*19
  - t<=30: 490+(t-25)*18
  - else: 598+(t-31)*17
  - Track 35 ends at LBA 682.
- Buffer address is {sector, byte}. The GCR port uses {sector, byte_addr}; the SD port uses {cur_sec, sd_buff_addr}.
- Dirty bitmap (SECT_MAX bits):
  - A bit sets on ram_we & ram_ready & ~img_readonly.
  - GCR writes while ram_ready=0 are ignored.
- Settle: the counter resets on any change of the clamped track. A load is requested when the count reaches SETTLE_CYCLES and the clamped track differs from loaded_track.
- FSM:
  - IDLE -> WB_SCAN on a load request or an img_mounted pulse. ram_ready drops the same cycle.
  - WB_SCAN: selects the lowest set dirty bit as cur_sec, sets sd_lba = start(loaded_track)+cur_sec, then -> WB_REQ. With no bit set, or loaded_track=0: cur_sec=0, latches target track, -> RD_REQ.
  - WB_REQ: sd_wr=1 until sd_ack rises, then sd_wr=0 -> WB_XFER.
  - WB_XFER: on sd_ack falling, clears dirty[cur_sec] -> WB_SCAN.
  - RD_REQ: sd_lba = start(target)+cur_sec; sd_rd=1 until sd_ack rises -> RD_XFER.
  - RD_XFER: buffer written on each sd_buff_wr. On sd_ack falling: if cur_sec = count(target)-1, then loaded_track=target and -> DONE; else cur_sec+1 -> RD_REQ.
  - DONE: if the settled track equals loaded_track, ram_ready=1 -> IDLE; otherwise -> RD_REQ with cur_sec=0 and the new target.
- Track change mid-read: the current block transfer completes; the restart happens at DONE (no abort of an SD handshake).
- Track change mid-writeback: all dirty sectors of the old track are written first.
- img_mounted:
  - Dirty bitmap is cleared without writeback; loaded_track=0.
  - A load of the current track is forced.
  - If a transfer is active, the mount takes effect when sd_ack falls.
- img_readonly=1 suppresses dirty marking; WB states are never entered.

Decomposition:
- Shared package c1541_pkg holds:
  - D64 track/sector constants (35 tracks, zone boundaries 17/24/30, sector counts 21/19/18/17, zone base LBAs 0/357/490/598)
  - the start_lba and sectors_per_track functions
  - the loader state enum
- Sub-module c1541_track_buf: true dual-port synchronous RAM, 8-bit wide, SECT_MAX*256 deep, both ports registered read.

Test Plan:
- Reset, track=1, hold SETTLE_CYCLES -> sd_rd for LBA 0..20 in order; ram_ready=1 after the 21st sd_ack fall; ram_do at {3,0x10} equals the image byte.
- track=18 settled -> LBAs 357..375 (19 reads), no sd_wr.
- On track 1, GCR writes sector 5 byte 0 = 0xAA, then track=2 -> one sd_wr at LBA 5 carrying 0xAA at offset 0, then reads from LBA 21.
- track changes 1->2 during the read of LBA 7 -> LBA 7 completes, then reads restart at LBA 21; ram_ready stays 0 throughout.
- img_readonly=1 with GCR writes, then track change -> no sd_wr issued.
- track=0 -> loads track 1; track=40 -> loads LBAs 666..682.
